// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin arbiter that lets four clients share one port of
//               a synchronous RAM with a one-cycle registered read output.
//               The winning request is registered onto the RAM command lines,
//               the winner receives a one-cycle grant pulse, and returned read
//               data is steered back with a per-client valid strobe.
//
// Ports       : clk          single clock, all state changes on posedge
//               rst_n        synchronous active-low reset
//               req_i[4]     per-client request, held until gnt_o is seen
//               we_i[4]      per-client write flag, qualified by req_i
//               addr_i       packed client addresses, client k at
//                            [k*ADDR_WIDTH +: ADDR_WIDTH]
//               wdata_i      packed client write data, same packing
//               gnt_o[4]     one-hot grant pulse
//               rvalid_o[4]  one-hot read-return pulse
//               rdata_o      shared read data (copy of ram_q_i)
//               ram_addr_o   registered RAM address
//               ram_data_o   registered RAM write data
//               ram_we_o     registered RAM write enable
//               ram_q_i      RAM registered read data
//
// Config      : RAM_ARB_WRITE_ACK_EN - when defined, writes also produce an
//               rvalid_o pulse one cycle after their grant (the RAM port is
//               write-through, so rdata_o then carries the written word).
//
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              req_i,
    input  logic [3:0]              we_i,
    input  logic [4*ADDR_WIDTH-1:0] addr_i,
    input  logic [4*DATA_WIDTH-1:0] wdata_i,
    output logic [3:0]              gnt_o,
    output logic [3:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_data_o,
    output logic                    ram_we_o,
    input  logic [DATA_WIDTH-1:0]   ram_q_i
);

    localparam int c_NUM_CLIENTS = 4;

`ifdef RAM_ARB_WRITE_ACK_EN
    localparam logic c_WRITE_ACK = 1'b1;
`else
    localparam logic c_WRITE_ACK = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Unpacked views of the packed client buses
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_addr  [c_NUM_CLIENTS];
    logic [DATA_WIDTH-1:0] w_wdata [c_NUM_CLIENTS];

    for (genvar k = 0; k < c_NUM_CLIENTS; k++) begin : g_unpack
        assign w_addr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]            gnt_q,      gnt_d;
    logic [1:0]            last_ptr_q, last_ptr_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_we_q,   ram_we_d;
    // Read tag travels with the command; return tag lines up with ram_q_i.
    logic                  rd_valid_q, rd_valid_d;
    logic [1:0]            rd_id_q,    rd_id_d;
    logic                  ret_valid_q, ret_valid_d;
    logic [1:0]            ret_id_q,    ret_id_d;

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    logic [3:0] w_eligible;
    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_idx;

    always_comb begin
        // A client being granted this cycle is masked so a request still
        // held during its grant cycle is not issued a second time.
        w_eligible = req_i & ~gnt_q;
        w_found    = 1'b0;
        w_winner   = last_ptr_q;
        w_idx      = last_ptr_q;
        // Offsets 1..4 from last_ptr; offset 4 wraps to last_ptr itself,
        // which therefore has the lowest priority.
        for (int i = 1; i <= c_NUM_CLIENTS; i++) begin
            w_idx = last_ptr_q + 2'(i);
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d      = 4'b0000;
        last_ptr_d = last_ptr_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_id_d    = rd_id_q;

        if (w_found) begin
            gnt_d[w_winner] = 1'b1;
            last_ptr_d      = w_winner;
            ram_addr_d      = w_addr[w_winner];
            ram_data_d      = w_wdata[w_winner];
            ram_we_d        = we_i[w_winner];
            rd_valid_d      = c_WRITE_ACK | ~we_i[w_winner];
            rd_id_d         = w_winner;
        end

        ret_valid_d = rd_valid_q;
        ret_id_d    = rd_id_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q       <= 4'b0000;
            last_ptr_q  <= 2'd3;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_id_q     <= 2'd0;
            ret_valid_q <= 1'b0;
            ret_id_q    <= 2'd0;
        end else begin
            gnt_q       <= gnt_d;
            last_ptr_q  <= last_ptr_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_we_q    <= ram_we_d;
            rd_valid_q  <= rd_valid_d;
            rd_id_q     <= rd_id_d;
            ret_valid_q <= ret_valid_d;
            ret_id_q    <= ret_id_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_o = 4'b0000;
        if (ret_valid_q) begin
            rvalid_o = 4'b0001 << ret_id_q;
        end
    end

    assign gnt_o      = gnt_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_data_o = ram_data_q;
    assign ram_we_o   = ram_we_q;
    assign rdata_o    = ram_q_i;

endmodule
`default_nettype wire
